// File: rtl/mem_cmd_responder.sv
// Executes one software-register memory command at a time over an arbitrated memory port.
// Optional macro MEM_RESP_BOUNDS_CHECK_EN rejects addresses wider than ADDR_WIDTH with an error.
module mem_cmd_responder #(
   parameter int ADDR_WIDTH = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           mem_addr_reg,
   input  logic [31:0]           mem_data_write_reg,
   input  logic [31:0]           mem_cmd_reg,
   output logic [31:0]           mem_data_read_reg,
   output logic [31:0]           mem_status_reg,
   output logic                  mem_req,
   input  logic                  mem_gnt,
   output logic                  mem_port_en,
   output logic                  mem_port_we,
   output logic [ADDR_WIDTH-1:0] mem_port_addr,
   output logic [31:0]           mem_port_wdata,
   input  logic [31:0]           mem_port_rdata
);
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACCESS, S_WAIT, S_DONE} state_t;

   localparam logic [1:0] OP_RD  = 2'b01;
   localparam logic [1:0] OP_WR  = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   state_t                state_q, state_d;
   logic [1:0]            op_q, op_d;
   logic [7:0]            acc_tag_q, acc_tag_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  err_pend_q, err_pend_d;
   logic [1:0]            wait_cnt_q, wait_cnt_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [7:0]            done_tag_q, done_tag_d;
   logic [15:0]           count_q, count_d;
   logic                  error_q, error_d;

   logic accept, is_rw, out_of_range, wait_last, busy;
   logic unused_bits;

   assign accept    = (state_q == S_IDLE) && (mem_cmd_reg[15:8] != acc_tag_q);
   assign is_rw     = (mem_cmd_reg[1:0] == OP_RD) || (mem_cmd_reg[1:0] == OP_WR);
   assign wait_last = (wait_cnt_q == 2'(RD_LATENCY - 1));

`ifdef MEM_RESP_BOUNDS_CHECK_EN
   assign out_of_range = (mem_addr_reg >> ADDR_WIDTH) != 32'd0;
`else
   assign out_of_range = 1'b0;
`endif

   assign unused_bits = ^{mem_cmd_reg[31:16], mem_cmd_reg[7:2], mem_addr_reg};

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = (is_rw && !out_of_range) ? S_REQ : S_DONE;
         S_REQ:    if (mem_gnt) state_d = S_ACCESS;
         S_ACCESS: state_d = (op_q == OP_WR) ? S_DONE : S_WAIT;
         S_WAIT:   if (wait_last) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy        = (state_q != S_IDLE);
      mem_req     = (state_q == S_REQ) || (state_q == S_ACCESS) || (state_q == S_WAIT);
      mem_port_en = (state_q == S_ACCESS);
      mem_port_we = (state_q == S_ACCESS) && (op_q == OP_WR);
   end

   // Command fields are frozen at acceptance; status only moves on the DONE cycle.
   always_comb begin
      op_d       = op_q;
      acc_tag_d  = acc_tag_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_pend_d = err_pend_q;
      wait_cnt_d = wait_cnt_q;
      rdata_d    = rdata_q;
      done_tag_d = done_tag_q;
      count_d    = count_q;
      error_d    = error_q;
      if (accept) begin
         op_d       = mem_cmd_reg[1:0];
         acc_tag_d  = mem_cmd_reg[15:8];
         addr_d     = mem_addr_reg[ADDR_WIDTH-1:0];
         wdata_d    = mem_data_write_reg;
         err_pend_d = (mem_cmd_reg[1:0] == OP_ILL) || (is_rw && out_of_range);
      end
      if (state_q == S_ACCESS) wait_cnt_d = 2'd0;
      if (state_q == S_WAIT) begin
         wait_cnt_d = wait_cnt_q + 2'd1;
         if (wait_last) rdata_d = mem_port_rdata;
      end
      if (state_q == S_DONE) begin
         done_tag_d = acc_tag_q;
         count_d    = count_q + 16'd1;
         error_d    = err_pend_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q       <= 2'b00;
         acc_tag_q  <= 8'd0;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
         err_pend_q <= 1'b0;
         wait_cnt_q <= 2'd0;
         rdata_q    <= 32'd0;
         done_tag_q <= 8'd0;
         count_q    <= 16'd0;
         error_q    <= 1'b0;
      end else begin
         op_q       <= op_d;
         acc_tag_q  <= acc_tag_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         err_pend_q <= err_pend_d;
         wait_cnt_q <= wait_cnt_d;
         rdata_q    <= rdata_d;
         done_tag_q <= done_tag_d;
         count_q    <= count_d;
         error_q    <= error_d;
      end
   end

   assign mem_port_addr     = addr_q;
   assign mem_port_wdata    = wdata_q;
   assign mem_data_read_reg = rdata_q;
   assign mem_status_reg    = {count_q, done_tag_q, 6'd0, error_q, busy};

endmodule

// File: tb/tb_mem_cmd_responder.sv
// Scoreboard bench for mem_cmd_responder: a word-array reference model predicts port accesses
// and completion status; a monitor compares them whenever the DUT accesses memory or completes.
`timescale 1ns/1ps
module tb_mem_cmd_responder;
   localparam int AW = 8;
   localparam int RL = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   mem_addr_reg, mem_data_write_reg, mem_cmd_reg;
   logic [31:0]   mem_data_read_reg, mem_status_reg;
   logic          mem_req, mem_gnt, mem_port_en, mem_port_we;
   logic [AW-1:0] mem_port_addr;
   logic [31:0]   mem_port_wdata, mem_port_rdata;

   mem_cmd_responder #(.ADDR_WIDTH(AW), .RD_LATENCY(RL)) dut (
      .clk(clk), .reset(reset),
      .mem_addr_reg(mem_addr_reg), .mem_data_write_reg(mem_data_write_reg),
      .mem_cmd_reg(mem_cmd_reg), .mem_data_read_reg(mem_data_read_reg),
      .mem_status_reg(mem_status_reg), .mem_req(mem_req), .mem_gnt(mem_gnt),
      .mem_port_en(mem_port_en), .mem_port_we(mem_port_we), .mem_port_addr(mem_port_addr),
      .mem_port_wdata(mem_port_wdata), .mem_port_rdata(mem_port_rdata));

   always #5 clk = ~clk;

   typedef struct { logic we; logic [AW-1:0] addr; logic [31:0] wdata; } acc_t;
   typedef struct { logic [31:0] status; logic [31:0] rdata; int cyc; } cmp_t;

   acc_t        exp_acc[$];
   cmp_t        exp_cmp[$];
   int          checks = 0, failures = 0, cyc = 0;
   logic [31:0] ref_mem [256];
   logic [31:0] dev_mem [256];
   logic [31:0] rd_sh [3];
   logic [15:0] m_count = 16'd0;
   logic [31:0] m_rdata = 32'd0;
   logic [7:0]  m_acc_tag = 8'd0;
   int          gnt_mode = 0;   // 0 = granted, 1 = withheld, 2 = random
   logic        gnt_rnd = 1'b1;

   assign mem_gnt = (gnt_mode == 2) ? gnt_rnd : (gnt_mode == 0);
   always @(negedge clk) gnt_rnd = $urandom_range(0, 1);

   // Memory device with RL-cycle read latency; non-read slots carry junk.
   always @(posedge clk) begin
      if (mem_port_en && mem_port_we) dev_mem[mem_port_addr] <= mem_port_wdata;
      rd_sh[0] <= (mem_port_en && !mem_port_we) ? dev_mem[mem_port_addr] : $urandom;
      rd_sh[1] <= rd_sh[0];
      rd_sh[2] <= rd_sh[1];
   end
   assign mem_port_rdata = rd_sh[RL-1];

   function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endfunction

   function automatic bit is_oob(input logic [31:0] addr);
`ifdef MEM_RESP_BOUNDS_CHECK_EN
      return (addr >> AW) != 32'd0;
`else
      return 1'b0;
`endif
   endfunction

   // Cycles from acceptance to the status update: DONE only, REQ/ACCESS/DONE, or plus RL of WAIT.
   function automatic int cmd_cycles(input logic [1:0] op, input logic [31:0] addr);
      if (!(op == 2'b01 || op == 2'b10) || is_oob(addr)) return 1;
      return (op == 2'b10) ? 3 : 3 + RL;
   endfunction

   function automatic void model_cmd(input logic [1:0] op, input logic [7:0] tag,
                                     input logic [31:0] addr, input logic [31:0] data, input int lat);
      acc_t a;
      cmp_t c;
      logic rw;
      logic [7:0] ea;
      if (tag == m_acc_tag) return;
      m_acc_tag = tag;
      rw = (op == 2'b01) || (op == 2'b10);
      ea = addr[AW-1:0];
      if (rw && !is_oob(addr)) begin
         a.we = (op == 2'b10);
         a.addr = ea;
         a.wdata = data;
         exp_acc.push_back(a);
         if (a.we) ref_mem[ea] = data;
         else      m_rdata = ref_mem[ea];
      end
      m_count = m_count + 16'd1;
      c.status = {m_count, tag, 6'd0, (op == 2'b11) || (rw && is_oob(addr)), 1'b0};
      c.rdata = m_rdata;
      c.cyc = lat;
      exp_cmp.push_back(c);
   endfunction

   function automatic void model_reset();
      m_count = 16'd0;
      m_rdata = 32'd0;
      m_acc_tag = 8'd0;
      exp_acc.delete();
      exp_cmp.delete();
   endfunction

   // Monitor: sampled 1ns after each rising edge.
   logic [15:0] prev_cnt = 16'd0;
   logic [31:0] prev_rd = 32'd0;
   always @(posedge clk) begin
      acc_t a;
      cmp_t c;
      cyc++;
      #1;
      if (reset) begin
         prev_cnt = 16'd0;
         prev_rd = 32'd0;
      end else begin
         if (mem_port_en) begin
            if (exp_acc.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_access actual=addr %h we %b required=no access", mem_port_addr, mem_port_we);
            end else begin
               a = exp_acc.pop_front();
               chk32("acc_we", {31'd0, mem_port_we}, {31'd0, a.we});
               chk32("acc_addr", {24'd0, mem_port_addr}, {24'd0, a.addr});
               if (a.we) chk32("acc_wdata", mem_port_wdata, a.wdata);
               chk32("acc_req", {31'd0, mem_req}, 32'd1);
            end
         end
         if (!mem_status_reg[0] && mem_req) begin
            checks++; failures++;
            $display("FAIL req_when_idle actual=1 required=0");
         end
         if (mem_status_reg[31:16] != prev_cnt) begin
            if (exp_cmp.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_completion actual=%h required=none", mem_status_reg);
            end else begin
               c = exp_cmp.pop_front();
               chk32("status", mem_status_reg, c.status);
               chk32("read_data", mem_data_read_reg, c.rdata);
               if (c.cyc >= 0) chk32("latency_cycle", cyc, c.cyc);
            end
            prev_cnt = mem_status_reg[31:16];
         end else if (mem_data_read_reg != prev_rd &&
                      (exp_cmp.size() == 0 || exp_cmp[0].rdata != mem_data_read_reg)) begin
            checks++; failures++;
            $display("FAIL read_reg_changed actual=%h required=%h", mem_data_read_reg, prev_rd);
         end
         prev_rd = mem_data_read_reg;
      end
   end

   task automatic wait_busy(input logic val, output bit ok);
      int n;
      n = 0;
      while (mem_status_reg[0] !== val && n < 400) begin
         @(negedge clk);
         n++;
      end
      ok = (mem_status_reg[0] === val);
      if (!ok) begin
         checks++; failures++;
         $display("FAIL busy_wait actual=%b required=%b", mem_status_reg[0], val);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [7:0] tag, input logic [31:0] addr,
                        input logic [31:0] data, input bit chk_lat, input bit scramble);
      bit ok;
      wait_busy(1'b0, ok);
      mem_addr_reg = addr;
      mem_data_write_reg = data;
      mem_cmd_reg = {16'($urandom), tag, 6'($urandom), op};
      model_cmd(op, tag, addr, data, chk_lat ? cyc + 1 + cmd_cycles(op, addr) : -1);
      @(negedge clk);
      if (scramble) begin
         mem_addr_reg = $urandom;
         mem_data_write_reg = $urandom;
      end
   endtask

   // Call right after issuing a read: two tag changes while busy, only the second may run.
   task automatic tag_swap();
      logic [7:0] tx, ty;
      logic [1:0] oy;
      logic [31:0] ay, dy;
      bit ok;
      do tx = 8'($urandom); while (tx == m_acc_tag);
      do ty = 8'($urandom); while (ty == m_acc_tag);
      mem_cmd_reg = {16'h0, tx, 6'h0, 2'($urandom)};
      mem_addr_reg = $urandom_range(0, 255);
      mem_data_write_reg = $urandom;
      @(negedge clk);
      oy = 2'($urandom);
      ay = $urandom_range(0, 255);
      dy = $urandom;
      mem_cmd_reg = {16'h0, ty, 6'h0, oy};
      mem_addr_reg = ay;
      mem_data_write_reg = dy;
      model_cmd(oy, ty, ay, dy, -1);
      wait_busy(1'b0, ok);
      if (ok) wait_busy(1'b1, ok);
   endtask

   task automatic check_zero(input string pfx);
      chk32({pfx, "_req"}, {31'd0, mem_req}, 32'd0);
      chk32({pfx, "_en"}, {31'd0, mem_port_en}, 32'd0);
      chk32({pfx, "_we"}, {31'd0, mem_port_we}, 32'd0);
      chk32({pfx, "_addr"}, {24'd0, mem_port_addr}, 32'd0);
      chk32({pfx, "_wdata"}, mem_port_wdata, 32'd0);
      chk32({pfx, "_rdata"}, mem_data_read_reg, 32'd0);
      chk32({pfx, "_status"}, mem_status_reg, 32'd0);
   endtask

   initial begin
      bit ok;
      logic [1:0] op;
      logic [7:0] tag;
      logic [31:0] addr;
      bit fresh;
      int n;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = $urandom;
         dev_mem[i] = ref_mem[i];
      end
      reset = 1'b1;
      mem_addr_reg = 32'd0;
      mem_data_write_reg = 32'd0;
      mem_cmd_reg = 32'd0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;

      issue(2'b10, 8'h01, 32'h05, 32'hDEADBEEF, 1'b1, 1'b1);
      issue(2'b01, 8'h02, 32'h05, 32'h0, 1'b1, 1'b0);

      wait_busy(1'b0, ok);
      gnt_mode = 1;
      issue(2'b01, 8'h03, 32'h05, $urandom, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         chk32("gnt_wait_req", {31'd0, mem_req}, 32'd1);
         chk32("gnt_wait_en", {31'd0, mem_port_en}, 32'd0);
         @(negedge clk);
      end
      gnt_mode = 0;
      @(negedge clk);
      chk32("access_after_gnt", {31'd0, mem_port_en}, 32'd1);

      issue(2'b11, 8'h04, 32'h07, $urandom, 1'b1, 1'b0);
      issue(2'b10, 8'h05, 32'h100, 32'h12345678, 1'b1, 1'b0);
      issue(2'b01, 8'h06, 32'h00, 32'h0, 1'b1, 1'b0);
      issue(2'b01, 8'h07, 32'h2A, 32'h0, 1'b1, 1'b0);
      tag_swap();
      issue(2'b00, 8'h0B, 32'h0, 32'h0, 1'b1, 1'b0);
      issue(2'b00, 8'h0B, 32'h9, 32'h55, 1'b0, 1'b0);

      // Reset during the first WAIT cycle of a read.
      issue(2'b01, 8'h0C, 32'h11, 32'h0, 1'b0, 1'b0);
      n = 0;
      while (!mem_port_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk32("reset_test_access", {31'd0, mem_port_en}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      mem_cmd_reg = 32'h0000_0001;
      model_reset();
      @(negedge clk);
      check_zero("wait_reset");
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk32("tag0_status", mem_status_reg, 32'd0);
      chk32("tag0_rdata", mem_data_read_reg, 32'd0);

      gnt_mode = 2;
      for (int i = 0; i < 150; i++) begin
         n = $urandom_range(0, 7);
         op = (n == 0) ? 2'b00 : (n == 1) ? 2'b11 : (n < 5) ? 2'b01 : 2'b10;
         if ($urandom_range(0, 15) == 0) tag = m_acc_tag;
         else do tag = 8'($urandom); while (tag == m_acc_tag);
         fresh = (tag != m_acc_tag);
         addr = $urandom_range(0, 255);
         if ($urandom_range(0, 5) == 0) addr = addr | (32'($urandom_range(1, 255)) << 8);
         issue(op, tag, addr, $urandom, 1'b0, 1'($urandom));
         if (fresh && op == 2'b01 && !is_oob(addr) && $urandom_range(0, 5) == 0) tag_swap();
      end

      n = 0;
      while ((exp_acc.size() != 0 || exp_cmp.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk32("drain_accesses", exp_acc.size(), 32'd0);
      chk32("drain_completions", exp_cmp.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_cmd_responder.md
MEM_CMD_RESPONDER -- requirements
Module: mem_cmd_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, word-address width of the attached memory port.
REQ-002 SHALL have parameter RD_LATENCY, default 1, memory read latency in cycles (legal 1..3).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_addr_reg  input  32  software-register word address.
REQ-006 SHALL have port mem_data_write_reg  input  32  software-register write data.
REQ-007 SHALL have port mem_cmd_reg  input  32  software command: [1:0] op (00 nop, 01 read, 10 write, 11 illegal), [15:8] tag.
REQ-008 SHALL have port mem_data_read_reg  output  32  last read data, hardware register.
REQ-009 SHALL have port mem_status_reg  output  32  [0] busy, [1] error, [15:8] last completed tag, [31:16] completed-command count.
REQ-010 SHALL have port mem_req  output  1  request for memory port ownership from the processor arbiter.
REQ-011 SHALL have port mem_gnt  input  1  arbiter grant, held while owned.
REQ-012 SHALL have ports mem_port_en/mem_port_we  output  1/1  memory port enable / write enable.
REQ-013 SHALL have ports mem_port_addr  output  ADDR_WIDTH, mem_port_wdata  output  32, mem_port_rdata  input  32.

Function
REQ-014 SHALL accept a new command only in IDLE, when mem_cmd_reg[15:8] differs from the last accepted tag.
REQ-015 SHALL latch op, tag, address, write data at acceptance; later register changes SHALL not affect the command in flight.
REQ-016 SHALL use states IDLE, REQ, ACCESS, WAIT, DONE; busy = 1 in every state except IDLE.
REQ-017 IDLE->REQ on accepted read/write; IDLE->DONE on accepted nop or illegal op (no memory access).
REQ-018 REQ: mem_req = 1 until the cycle after mem_gnt is sampled high, then ->ACCESS; no timeout.
REQ-019 ACCESS: exactly one cycle of mem_port_en = 1 (mem_port_we = 1 for write) with latched addr/wdata; write->DONE, read->WAIT.
REQ-020 WAIT: count RD_LATENCY cycles after ACCESS, capture mem_port_rdata into mem_data_read_reg in the last one, ->DONE.
REQ-021 mem_req SHALL remain 1 from REQ through WAIT inclusive and drop in DONE.
REQ-022 DONE (one cycle): tag field <= latched tag, count += 1 (16-bit wrap 0xFFFF->0x0000), error <= 1 for illegal op else 0, ->IDLE.
REQ-023 Read-to-status latency: status tag update SHALL appear 3+RD_LATENCY cycles after acceptance given mem_gnt already high.
REQ-024 mem_data_read_reg SHALL hold its value except on read capture; writes and nops SHALL not alter it.
REQ-025 Tag change during busy SHALL be accepted the cycle after returning to IDLE; only the latest tag value SHALL be seen.
REQ-026 mem_gnt dropping during ACCESS/WAIT SHALL not abort the access.

Reset
REQ-027 Reset SHALL force IDLE, mem_req/mem_port_en/mem_port_we = 0, mem_port_addr/wdata = 0, mem_data_read_reg = 0, mem_status_reg = 0, accepted tag = 0.
REQ-028 Reset mid-operation SHALL abandon the command without status update; a command with tag 0 after reset SHALL not execute.

Configuration
REQ-029 Macro MEM_RESP_BOUNDS_CHECK_EN defined: accepted read/write with mem_addr_reg[31:ADDR_WIDTH] != 0 SHALL go IDLE->DONE with error = 1, no mem_req, no access.
REQ-030 Macro undefined: address SHALL be truncated to ADDR_WIDTH bits and always accessed; error set only by illegal op.

Verification
REQ-031 Write: addr 0x05, data 0xDEADBEEF, cmd 0x0102, gnt tied 1 -> one en+we pulse at addr 0x05; status 0x0001_0100.
REQ-032 Read after write: cmd 0x0201, RD_LATENCY 2 -> mem_data_read_reg 0xDEADBEEF; status 0x0002_0200, status at 5 cycles post-accept.
REQ-033 gnt withheld 10 cycles on read tag 0x03 -> mem_req high, en low throughout; access the cycle after gnt rises.
REQ-034 Illegal op cmd 0x0403 -> no en; status error 1, tag 0x04; next valid cmd clears error.
REQ-035 Addr 0x100 with ADDR_WIDTH 8, bounds macro on -> error 1, no access; macro off -> access at addr 0x00.
REQ-036 Reset asserted in WAIT -> all outputs 0 next cycle; held cmd tag 0 -> no activity.
